fifo_burst_reader: RTL and testbench

- Read-side engine for the team's FIFO interface (empty / rd_en / rdata, registered read data).
- On a start command it pulls exactly burst_len words out of the FIFO and never asserts rd_en while empty, so the FIFO cannot underflow.
- It delivers the words on a downstream valid/ready stream through a small output buffer that absorbs the FIFO's 1-cycle read latency and downstream back-pressure.
- Single clock domain: sits on the FIFO's read clock.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_burst_reader_if.sv | 28 ++
 rtl/fifo_out_buf.sv | 87 ++++++++
 rtl/fifo_burst_reader.sv | 126 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and default widths.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LEN_W = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the burst reader.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rdata;

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    // master: the reader engine; slave: the FIFO and downstream consumer side.
    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/fifo_out_buf.sv
// Small circular buffer of {last, data} entries between the FIFO read port and the stream.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               res,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               push_last,
    input  logic               pop,
    input  logic               mark_tail,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]   head_data,
    output logic               head_last
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] last_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] mark_hit;

    assign tail_ptr = wr_ptr_reg - 1'b1;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi]   = push && (wr_ptr_reg == PTR_W'(gi));
            assign mark_hit[gi] = mark_tail && (count_reg != '0) && (tail_ptr == PTR_W'(gi));
        end
    endgenerate

    // Payload storage carries no reset so it can map onto distributed memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Last flags live in flops: an early stop may retag the newest entry after it was written.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            last_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    last_reg[i] <= push_last;
                end else if (mark_hit[i]) begin
                    last_reg[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];
    assign head_last = last_reg[rd_ptr_reg];

endmodule

// File: rtl/fifo_burst_reader.sv
// Pulls a fixed-length burst out of a FIFO without underflow and streams it out on valid/ready.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LEN_W     = DEFAULT_LEN_W,
    parameter int OUT_DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] rd_count,
    fifo_burst_reader_if.master bus
);

    localparam int CNT_W = cnt_width(OUT_DEPTH);

    state_t           state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] rd_count_reg;
    logic             inflight_reg;
    logic             inflight_last_reg;

    logic [CNT_W-1:0] buf_cnt;
    logic [WIDTH-1:0] head_data;
    logic             head_last;

    logic             rd_en;
    logic             room;
    logic             abort_now;
    logic             buf_valid;
    logic             pop;
    logic             push_last;
    logic             mark_tail;

    // Words already requested from the FIFO count against buffer space too.
    assign room      = (buf_cnt + {{(CNT_W-1){1'b0}}, inflight_reg}) < CNT_W'(OUT_DEPTH);
    assign abort_now = (state_reg == ST_READ) && abort;
    assign rd_en     = (state_reg == ST_READ) && !bus.fifo_empty &&
                       (rd_count_reg < len_reg) && room && !abort;

    assign buf_valid = (buf_cnt != '0);
    assign pop       = buf_valid && bus.m_ready;

    // An early stop makes the most recently issued word the final one: tag it in flight,
    // or retag the newest buffered entry if it has already landed.
    assign push_last = inflight_last_reg || (abort_now && inflight_reg);
    assign mark_tail = abort_now && !inflight_reg;

    fifo_out_buf #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .res       (res),
        .push      (inflight_reg),
        .push_data (bus.fifo_rdata),
        .push_last (push_last),
        .pop       (pop),
        .mark_tail (mark_tail),
        .count     (buf_cnt),
        .head_data (head_data),
        .head_last (head_last)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg         <= ST_IDLE;
            len_reg           <= '0;
            rd_count_reg      <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= rd_en;
            inflight_last_reg <= rd_en && (rd_count_reg == len_reg - 1'b1);
            if (rd_en) begin
                rd_count_reg <= rd_count_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        rd_count_reg <= '0;
                        if (burst_len != '0) begin
                            len_reg   <= burst_len;
                            state_reg <= ST_READ;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    if (abort || (rd_count_reg == len_reg)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_reg && (buf_cnt == '0)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign rd_count = rd_count_reg;

    // Data and last are forced low whenever nothing is valid, including straight out of reset.
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = buf_valid;
    assign bus.m_data     = buf_valid ? head_data : '0;
    assign bus.m_last     = buf_valid && head_last;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: behavioural FIFO model feeding the burst reader, stream monitor, hand-computed checks.
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int WIDTH     = 8;
    localparam int LEN_W     = 8;
    localparam int OUT_DEPTH = 4;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] rd_count;

    fifo_burst_reader_if #(.WIDTH(WIDTH)) bus();

    fifo_burst_reader #(
        .WIDTH     (WIDTH),
        .LEN_W     (LEN_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: registered read data, empty reflects the post-read occupancy.
    logic [WIDTH-1:0] fq[$];
    bit               underflow = 0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (fq.size() == 0) underflow = 1;
            else bus.fifo_rdata <= fq.pop_front();
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(WIDTH'(base + i));
        bus.fifo_empty = (fq.size() == 0);
    endtask

    // Stream monitor, sampled on the falling edge.
    logic [WIDTH-1:0] xd_q[$];
    logic             xl_q[$];
    int               xc_q[$];
    int  iss_n, xfer_n, done_n, done_cyc, first_rd, last_rd, first_valid, max_out, rule_err;
    int  outstanding;
    bit  prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    task automatic clear_logs();
        xd_q.delete(); xl_q.delete(); xc_q.delete();
        iss_n = 0; xfer_n = 0; done_n = 0; done_cyc = -1;
        first_rd = -1; last_rd = -1; first_valid = -1;
        max_out = 0; rule_err = 0; prev_stall = 0; underflow = 0;
    endtask

    always @(negedge clk) begin
        if (res) begin
            outstanding = iss_n - xfer_n;
            if (outstanding > max_out) max_out = outstanding;
            if (bus.fifo_rd_en && outstanding >= OUT_DEPTH) rule_err++;
            if (prev_stall && !(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last))
                rule_err++;
            if (bus.fifo_rd_en) begin
                iss_n++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (bus.m_valid && first_valid < 0) first_valid = cyc;
            if (bus.m_valid && bus.m_ready) begin
                xd_q.push_back(bus.m_data);
                xl_q.push_back(bus.m_last);
                xc_q.push_back(cyc);
                xfer_n++;
                $display("xfer cyc=%0d data=0x%02h last=%0d", cyc, bus.m_data, bus.m_last);
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    int         start_cyc;
    logic [3:0] rdy_pat = 4'b1001;

    task automatic fire(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = LEN_W'(len);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc, input bit toggle);
        for (int i = 0; i < maxc && done_n == 0; i++) begin
            if (toggle) bus.m_ready = rdy_pat[cyc % 4];
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_done_pulses"}, done_n, 1);
        check_val({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        check_val({tag, "_words"}, xd_q.size(), n);
        for (int i = 0; i < xd_q.size() && i < n; i++) begin
            check_val($sformatf("%s_data%0d", tag, i), xd_q[i], 32'(base + i));
            check_val($sformatf("%s_last%0d", tag, i), xl_q[i], (i == n - 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_ready    = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        res = 1'b1;
        @(posedge clk); #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_rd_en", bus.fifo_rd_en, 1'b0);
        check_val("rst_m_valid", bus.m_valid, 1'b0);
        check_val("rst_m_data", bus.m_data, 0);
        check_val("rst_m_last", bus.m_last, 1'b0);
        check_val("rst_rd_count", rd_count, 0);

        // Full-rate burst of 16.
        clear_logs();
        load(8'h10, 16);
        fire(16);
        wait_done("t1", 100, 0);
        check_stream("t1", 8'h10, 16);
        check_val("t1_issues", iss_n, 16);
        check_val("t1_issue_span", last_rd - first_rd, 15);
        check_val("t1_latency", first_valid - first_rd, 2);
        if (xc_q.size() == 16) begin
            check_val("t1_xfer_span", xc_q[15] - xc_q[0], 15);
            check_val("t1_done_gap", done_cyc - xc_q[15], 2);
        end
        check_val("t1_rd_count", rd_count, 16);
        check_val("t1_underflow", underflow, 1'b0);

        // FIFO runs dry mid-burst, refilled 20 clocks later.
        clear_logs();
        load(8'h20, 3);
        fire(5);
        repeat (20) @(posedge clk);
        #1;
        check_val("t2_busy_paused", busy, 1'b1);
        check_val("t2_count_paused", rd_count, 3);
        load(8'h23, 2);
        wait_done("t2", 60, 0);
        check_stream("t2", 8'h20, 5);
        check_val("t2_underflow", underflow, 1'b0);
        check_val("t2_rd_count", rd_count, 5);

        // Back-pressure with ready pattern 1,0,0,1.
        clear_logs();
        load(8'h30, 8);
        fire(8);
        wait_done("t3", 120, 1);
        check_stream("t3", 8'h30, 8);
        check_val("t3_max_outstanding", max_out, OUT_DEPTH);
        check_val("t3_rule_errors", rule_err, 0);
        check_val("t3_issues", iss_n, 8);

        // Abort after three issues.
        clear_logs();
        load(8'h50, 10);
        fire(10);
        for (int i = 0; i < 20 && rd_count != 3; i++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("t4", 60, 0);
        check_stream("t4", 8'h50, 3);
        check_val("t4_issues", iss_n, 3);
        check_val("t4_rd_count", rd_count, 3);
        fq.delete();
        bus.fifo_empty = 1'b1;

        // Zero-length burst.
        clear_logs();
        fire(0);
        wait_done("t5", 20, 0);
        check_val("t5_done_latency", done_cyc - start_cyc, 1);
        check_val("t5_issues", iss_n, 0);
        check_val("t5_rd_count", rd_count, 0);

        // Abort with nothing issued: no words and no last marker.
        clear_logs();
        fire(4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("t5b", 20, 0);
        check_val("t5b_words", xfer_n, 0);
        check_val("t5b_issues", iss_n, 0);

        // Second start while busy must be ignored.
        clear_logs();
        load(8'h60, 6);
        fire(6);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = LEN_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5c", 60, 0);
        check_stream("t5c", 8'h60, 6);
        check_val("t5c_rd_count", rd_count, 6);

        // Reset mid-burst, then resume from the next FIFO word.
        clear_logs();
        load(8'h70, 12);
        fire(12);
        for (int i = 0; i < 30 && rd_count != 5; i++) begin
            @(posedge clk); #1;
        end
        check_val("t6_valid_before", bus.m_valid, 1'b1);
        res = 1'b0;
        #1;
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_done", done, 1'b0);
        check_val("t6_rd_en", bus.fifo_rd_en, 1'b0);
        check_val("t6_m_valid", bus.m_valid, 1'b0);
        check_val("t6_m_data", bus.m_data, 0);
        check_val("t6_m_last", bus.m_last, 1'b0);
        check_val("t6_rd_count", rd_count, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("t6_fifo_left", fq.size(), 7);
        res = 1'b1;
        clear_logs();
        fire(4);
        wait_done("t6b", 60, 0);
        check_stream("t6b", 8'h75, 4);
        check_val("t6b_rd_count", rd_count, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
